// File: rtl/fifo_fwft_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_fwft_unpacker
//
// Sits directly behind the two-word FWFT FIFO. Pops one IN_BITS word and
// presents it downstream as RATIO = IN_BITS/OUT_BITS slices of OUT_BITS each,
// through another FWFT interface. Sustains one slice per clock. When a word
// follows immediately, there is no bubble between the last slice of one word
// and the first slice of the next.
//
// Configuration macro:
//   FIFO_UNPACK_MSB_FIRST_EN  defined   : most significant slice emitted first
//                             undefined : least significant slice emitted first
//   The macro only changes slice order. Handshake and timing are identical.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   in_not_empty   in   upstream FIFO presents a valid word on in_data
//   in_data        in   upstream FWFT word (IN_BITS)
//   in_shift_out   out  combinational pop strobe to the upstream FIFO
//   out_shift_out  in   downstream consumes the current slice
//   out_not_empty  out  out_data is valid
//   out_data       out  current slice (OUT_BITS)
//   out_first      out  current slice is slice 0 of its word
//   out_last       out  current slice is slice RATIO-1 of its word
//
// Handshake (both sides are FWFT): a transfer happens on a rising edge when
// the producer's not_empty and the consumer's shift_out are both high. Data is
// valid whenever not_empty is high, without waiting for shift_out. shift_out
// is ignored while not_empty is low. Once not_empty is high, data stays stable
// until the transfer happens.
// ---------------------------------------------------------------------------
module fifo_fwft_unpacker #(
    parameter int IN_BITS  = 32,
    parameter int OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_not_empty,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                in_shift_out,
    input  logic                out_shift_out,
    output logic                out_not_empty,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_first,
    output logic                out_last
);

    localparam int RATIO = IN_BITS / OUT_BITS;
    localparam int SEL_W = $clog2(RATIO);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);

    logic [IN_BITS-1:0]  hold_data;
    logic                hold_valid;
    logic [SEL_W-1:0]    sel;
    logic                take;
    logic                at_last;
    logic [OUT_BITS-1:0] slices [RATIO];

    // Slice k of the held word. The macro selects the order in which slices
    // are emitted. Indexing by sel is then a plain mux.
    for (genvar k = 0; k < RATIO; k++) begin : g_slice
`ifdef FIFO_UNPACK_MSB_FIRST_EN
        assign slices[k] = hold_data[IN_BITS-1-k*OUT_BITS -: OUT_BITS];
`else
        assign slices[k] = hold_data[k*OUT_BITS +: OUT_BITS];
`endif
    end

    assign take    = out_shift_out && hold_valid;
    assign at_last = (sel == SEL_LAST);

    // The pop is gated by reset. This prevents a word from being removed from
    // the FIFO in a cycle whose capture would then be lost to the reset.
    assign in_shift_out = !reset && in_not_empty && (!hold_valid || (take && at_last));

    assign out_not_empty = hold_valid;
    assign out_data      = slices[sel];
    assign out_first     = hold_valid && (sel == '0);
    assign out_last      = hold_valid && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            sel        <= '0;
        end else if (in_shift_out) begin
            hold_data  <= in_data;
            hold_valid <= 1'b1;
            sel        <= '0;
        end else if (take && at_last) begin
            // The word is drained. hold_data is left as is because nothing
            // reads it while hold_valid is low.
            hold_valid <= 1'b0;
            sel        <= '0;
        end else if (take) begin
            sel <= sel + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_fwft_unpacker.sv
module tb_fifo_fwft_unpacker;

  logic        clk;
  logic        reset;
  logic        in_not_empty;
  logic [31:0] in_data;
  logic        in_shift_out;
  logic        out_shift_out;
  logic        out_not_empty;
  logic [7:0]  out_data;
  logic        out_first;
  logic        out_last;

  int n_cmp;
  int n_err;

  fifo_fwft_unpacker #(
    .IN_BITS (32),
    .OUT_BITS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_not_empty (in_not_empty),
    .in_data      (in_data),
    .in_shift_out (in_shift_out),
    .out_shift_out(out_shift_out),
    .out_not_empty(out_not_empty),
    .out_data     (out_data),
    .out_first    (out_first),
    .out_last     (out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected slice k of a word, in the configured emission order.
  function automatic logic [7:0] exp_slice(input logic [31:0] w, input int k);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return w[31-8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  // Inputs change 1 time unit after the rising edge. Checks are made at the
  // falling edge, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check();
    #4;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_not_empty = 1'b1;
    in_data = 32'hDEADBEEF;
    out_shift_out = 1'b1;
    tick();
    tick();
    to_check();
    n_cmp++; if (in_shift_out !== 1'b0) begin n_err++; $display("FAIL reset_in_shift_out: got %b want 0", in_shift_out); end
    n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL reset_out_not_empty: got %b want 0", out_not_empty); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_first !== 1'b0) begin n_err++; $display("FAIL reset_out_first: got %b want 0", out_first); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    tick();
    in_not_empty = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  // Load one word while empty, then stream its four slices with no stall.
  task automatic test_single_word();
    logic [31:0] w;
    w = 32'h44332211;
    in_not_empty = 1'b1;
    in_data = w;
    out_shift_out = 1'b1;
    to_check();
    n_cmp++; if (in_shift_out !== 1'b1) begin n_err++; $display("FAIL single_pop: got %b want 1", in_shift_out); end
    n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL single_empty_before: got %b want 0", out_not_empty); end
    tick();
    in_not_empty = 1'b0;
    in_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      to_check();
      n_cmp++; if (out_not_empty !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", k, out_not_empty); end
      n_cmp++; if (out_data !== exp_slice(w, k)) begin n_err++; $display("FAIL single_data[%0d]: got %h want %h", k, out_data, exp_slice(w, k)); end
      n_cmp++; if (out_first !== (k == 0)) begin n_err++; $display("FAIL single_first[%0d]: got %b want %b", k, out_first, (k == 0)); end
      n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL single_last[%0d]: got %b want %b", k, out_last, (k == 3)); end
      n_cmp++; if (in_shift_out !== 1'b0) begin n_err++; $display("FAIL single_no_pop[%0d]: got %b want 0", k, in_shift_out); end
      tick();
    end
    to_check();
    n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b want 0", out_not_empty); end
    tick();
  endtask

  // Two words back-to-back: eight contiguous slices, pop in the A3 cycle.
  task automatic test_back_to_back();
    logic [31:0] wa;
    logic [31:0] wb;
    wa = 32'hA3A2A1A0;
    wb = 32'hB3B2B1B0;
    in_not_empty = 1'b1;
    in_data = wa;
    out_shift_out = 1'b1;
    to_check();
    n_cmp++; if (in_shift_out !== 1'b1) begin n_err++; $display("FAIL b2b_pop_a: got %b want 1", in_shift_out); end
    tick();
    in_data = wb;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) in_not_empty = 1'b0;
      to_check();
      n_cmp++; if (out_not_empty !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_not_empty); end
      n_cmp++; if (out_data !== exp_slice((k < 4) ? wa : wb, k % 4)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, out_data, exp_slice((k < 4) ? wa : wb, k % 4)); end
      n_cmp++; if (out_first !== (k % 4 == 0)) begin n_err++; $display("FAIL b2b_first[%0d]: got %b want %b", k, out_first, (k % 4 == 0)); end
      n_cmp++; if (out_last !== (k % 4 == 3)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", k, out_last, (k % 4 == 3)); end
      n_cmp++; if (in_shift_out !== (k == 3)) begin n_err++; $display("FAIL b2b_pop[%0d]: got %b want %b", k, in_shift_out, (k == 3)); end
      tick();
    end
    to_check();
    n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", out_not_empty); end
    tick();
  endtask

  // Stall for three cycles at sel=1 while another word waits upstream.
  task automatic test_stall();
    logic [31:0] w;
    w = 32'h0D0C0B0A;
    in_not_empty = 1'b1;
    in_data = w;
    out_shift_out = 1'b1;
    tick();
    in_data = 32'h99999999;
    in_not_empty = 1'b0;
    to_check();
    n_cmp++; if (out_data !== exp_slice(w, 0)) begin n_err++; $display("FAIL stall_slice0: got %h want %h", out_data, exp_slice(w, 0)); end
    tick();
    out_shift_out = 1'b0;
    in_not_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      to_check();
      n_cmp++; if (out_data !== exp_slice(w, 1)) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", c, out_data, exp_slice(w, 1)); end
      n_cmp++; if (in_shift_out !== 1'b0) begin n_err++; $display("FAIL stall_no_pop[%0d]: got %b want 0", c, in_shift_out); end
      n_cmp++; if (out_not_empty !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_not_empty); end
      tick();
    end
    out_shift_out = 1'b1;
    in_not_empty = 1'b0;
    for (int k = 1; k < 4; k++) begin
      to_check();
      n_cmp++; if (out_data !== exp_slice(w, k)) begin n_err++; $display("FAIL stall_resume[%0d]: got %h want %h", k, out_data, exp_slice(w, k)); end
      n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL stall_last[%0d]: got %b want %b", k, out_last, (k == 3)); end
      tick();
    end
    to_check();
    n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL stall_drained: got %b want 0", out_not_empty); end
    tick();
  endtask

  // Stay empty for idle cycles, then reload a word; it must start at slice 0.
  task automatic test_drain_reload();
    logic [31:0] w;
    w = 32'h55667788;
    in_not_empty = 1'b0;
    out_shift_out = 1'b1;
    for (int c = 0; c < 2; c++) begin
      to_check();
      n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL idle_empty[%0d]: got %b want 0", c, out_not_empty); end
      n_cmp++; if (in_shift_out !== 1'b0) begin n_err++; $display("FAIL idle_no_pop[%0d]: got %b want 0", c, in_shift_out); end
      tick();
    end
    in_not_empty = 1'b1;
    in_data = w;
    to_check();
    n_cmp++; if (in_shift_out !== 1'b1) begin n_err++; $display("FAIL reload_pop: got %b want 1", in_shift_out); end
    tick();
    in_not_empty = 1'b0;
    to_check();
    n_cmp++; if (out_first !== 1'b1) begin n_err++; $display("FAIL reload_first: got %b want 1", out_first); end
    n_cmp++; if (out_data !== exp_slice(w, 0)) begin n_err++; $display("FAIL reload_data: got %h want %h", out_data, exp_slice(w, 0)); end
    for (int k = 0; k < 4; k++) tick();
  endtask

  // Assert reset at sel=2. Outputs clear at once; the next word starts at slice 0.
  task automatic test_reset_mid_word();
    logic [31:0] w;
    logic [31:0] w2;
    w = 32'h87654321;
    w2 = 32'hCAFEF00D;
    in_not_empty = 1'b1;
    in_data = w;
    out_shift_out = 1'b1;
    tick();
    in_not_empty = 1'b0;
    tick();
    tick();
    to_check();
    n_cmp++; if (out_data !== exp_slice(w, 2)) begin n_err++; $display("FAIL mid_pre_data: got %h want %h", out_data, exp_slice(w, 2)); end
    in_not_empty = 1'b1;
    in_data = w2;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_not_empty !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_not_empty); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got %h want 00", out_data); end
    n_cmp++; if (out_first !== 1'b0) begin n_err++; $display("FAIL mid_rst_first: got %b want 0", out_first); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL mid_rst_last: got %b want 0", out_last); end
    n_cmp++; if (in_shift_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_pop: got %b want 0", in_shift_out); end
    tick();
    reset = 1'b0;
    to_check();
    n_cmp++; if (in_shift_out !== 1'b1) begin n_err++; $display("FAIL mid_after_pop: got %b want 1", in_shift_out); end
    tick();
    in_not_empty = 1'b0;
    for (int k = 0; k < 4; k++) begin
      to_check();
      n_cmp++; if (out_data !== exp_slice(w2, k)) begin n_err++; $display("FAIL mid_after_data[%0d]: got %h want %h", k, out_data, exp_slice(w2, k)); end
      n_cmp++; if (out_first !== (k == 0)) begin n_err++; $display("FAIL mid_after_first[%0d]: got %b want %b", k, out_first, (k == 0)); end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_drain_reload();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
